icache_fill_ctrl: RTL and testbench
===================================

// Module: icache_fill_ctrl
// PURPOSE
//  Direct-mapped I-cache lookup/refill controller. Sits between the CPU fetch port and the I-cache
//  state-tag RAM plus the data RAM; consumes the state-tag read word and drives its write port.
//  On a hit it returns the word. On a miss it bursts a 64-byte line from memory over an AXI-style
//  read channel, writes the line into the data RAM and marks the set Clean.
// PARAMETERS
//  SET_WIDTH    4   set index = addr[9:6]; 2**SET_WIDTH lines
//  STATE_WIDTH  2   line state: 2'b10 Invalid, 2'b01 Clean, 2'b00 Dirty (never written by I-cache)
//  TAG_WIDTH    22  tag = addr[31:10]
// PORTS
//  clk            in   1          clock
//  rst_n          in   1          synchronous, active-low reset
//  cpu_req        in   1          fetch request; held with cpu_addr stable until cpu_ready
//  cpu_addr       in   32         byte address (word-aligned, [1:0] ignored)
//  cpu_ready      out  1          one-cycle pulse: cpu_rdata valid
//  cpu_rdata      out  32         fetched instruction word
//  st_rw_addr     out  SET_WIDTH  state-tag RAM address
//  st_w_en        out  1          state-tag RAM write enable
//  st_w_state_tag out  24         {state, tag} write data
//  st_r_state_tag in   24         {state, tag} read data (1-cycle registered read)
//  dr_addr        out  SET+4      data RAM word address {set, word[5:2]}
//  dr_w_en        out  1          data RAM write enable
//  dr_wdata       out  32         data RAM write data
//  dr_rdata       in   32         data RAM read data (1-cycle registered read)
//  mem_arvalid    out  1          line read request
//  mem_araddr     out  32         line-aligned address {tag, set, 6'b0}
//  mem_arlen      out  8          constant 8'd15 (16 beats x 32 bit)
//  mem_arready    in   1          address accepted
//  mem_rvalid     in   1          read beat valid
//  mem_rdata      in   32         read beat data
//  mem_rlast      in   1          last beat
//  mem_rready     out  1          beat accept
// BEHAVIOUR
//  FSM: IDLE, LOOKUP, AR, REFILL, UPDATE. Reset -> IDLE.
//  Reset values: cpu_ready=0, cpu_rdata=0, st_w_en=0, dr_w_en=0, mem_arvalid=0, mem_rready=0.
//  Beat counter = 0.
//  IDLE: st_rw_addr=cpu_addr[9:6] and dr_addr=cpu_addr[9:2] combinationally. On cpu_req, latch
//   cpu_addr into req_addr and go to LOOKUP. In all other states, RAM addresses come from req_addr.
//  LOOKUP: hit = (st_r_state_tag[23:22] != 2'b10 && != 2'b11) && (st_r_state_tag[21:0] == req_addr[31:10]).
//   Hit: cpu_ready=1 and cpu_rdata=dr_rdata in this cycle, then IDLE. Hit latency is 1 cycle after req.
//   Miss: go to AR.
//  AR: mem_arvalid=1, mem_araddr={req_addr[31:6],6'b0}. arvalid holds until arready; then REFILL, counter=0.
//  REFILL: mem_rready=1. Each rvalid beat: dr_w_en=1, dr_addr={set,counter}, dr_wdata=mem_rdata,
//   counter+1. When counter==req_addr[5:2], capture mem_rdata into the fill word.
//   Exit to UPDATE on the beat where rlast=1 OR counter==15, whichever comes first.
//   No beat is accepted after exit.
//  UPDATE (1 cycle): st_w_en=1, st_w_state_tag={2'b01, req_addr[31:10]}. cpu_ready=1 with the
//   fill word, then IDLE. Miss latency = 1 + AR wait + 16 beats + 1.
//  Refill overwrites the set unconditionally; Dirty is never produced, so no writeback.
//  cpu_req still high in the cycle after cpu_ready: treated as a new request (fresh lookup).
//  Gaps in rvalid stall the counter. No time-out.
//  Reset mid-refill: abandon immediately. The state-tag entry is not written, so the line stays
//   at its prior state. The memory side is reset together with this block.
//  Post-reset RAM read output of 0 is never sampled: LOOKUP is entered only after an IDLE read.
// TESTING
//  1 Cold miss: req 0x0000_1044 after reset -> araddr 0x0000_1040, arlen 15. After 16 beats
//    (data=beat idx), st_w_en with {01,0x000004} at set 1; cpu_ready with rdata=1.
//  2 Hit: repeat req 0x0000_1048 -> cpu_ready exactly 1 cycle after req, rdata=2, no arvalid.
//  3 Conflict: req 0x0000_1440 (same set 1, tag 0x5) -> miss, refill, set 1 tag=0x5.
//    Then req 0x0000_1040 -> miss again.
//  4 Backpressure: arready low 5 cycles, rvalid gaps every other beat ->
//    arvalid/araddr held stable; all 16 words correct in data RAM.
//  5 Reset at beat 7 of refill -> all outputs at reset values next cycle.
//    The set is still Invalid, so a re-request misses.
//  6 Back-to-back req held high across hits -> one cpu_ready per lookup, every 2 cycles.

Source files
------------

// File: rtl/icache_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : icache_fill_ctrl
// Brief   : Direct-mapped I-cache lookup and 64-byte line refill controller.
// Revision: 1.0
// ============================================================================
module icache_fill_ctrl #(
    parameter int SET_WIDTH   = 4,
    parameter int STATE_WIDTH = 2,
    parameter int TAG_WIDTH   = 22
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             i_cpu_req,
    input  logic [31:0]                      i_cpu_addr,
    output logic                             o_cpu_ready,
    output logic [31:0]                      o_cpu_rdata,
    output logic [SET_WIDTH-1:0]             o_st_rw_addr,
    output logic                             o_st_w_en,
    output logic [STATE_WIDTH+TAG_WIDTH-1:0] o_st_w_state_tag,
    input  logic [STATE_WIDTH+TAG_WIDTH-1:0] i_st_r_state_tag,
    output logic [SET_WIDTH+3:0]             o_dr_addr,
    output logic                             o_dr_w_en,
    output logic [31:0]                      o_dr_wdata,
    input  logic [31:0]                      i_dr_rdata,
    output logic                             o_mem_arvalid,
    output logic [31:0]                      o_mem_araddr,
    output logic [7:0]                       o_mem_arlen,
    input  logic                             i_mem_arready,
    input  logic                             i_mem_rvalid,
    input  logic [31:0]                      i_mem_rdata,
    input  logic                             i_mem_rlast,
    output logic                             o_mem_rready
);

    localparam logic [STATE_WIDTH-1:0] c_ST_INVALID = STATE_WIDTH'(2'b10);
    localparam logic [STATE_WIDTH-1:0] c_ST_RSVD    = STATE_WIDTH'(2'b11);
    localparam logic [STATE_WIDTH-1:0] c_ST_CLEAN   = STATE_WIDTH'(2'b01);
    localparam logic [7:0]             c_ARLEN      = 8'd15;
    localparam logic [3:0]             c_LAST_WORD  = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_AR     = 3'd2,
        S_REFILL = 3'd3,
        S_UPDATE = 3'd4
    } state_t;

    state_t      r_state;
    logic [31:0] r_req_addr;
    logic [3:0]  r_beat;
    logic [31:0] r_fill_word;
    logic        r_arvalid;
    logic        r_rready;
    logic        r_update;

    logic [SET_WIDTH-1:0]   w_req_set;
    logic [TAG_WIDTH-1:0]   w_req_tag;
    logic [3:0]             w_req_word;
    logic [STATE_WIDTH-1:0] w_rd_state;
    logic [TAG_WIDTH-1:0]   w_rd_tag;
    logic                   w_hit;
    logic                   w_beat_acc;
    logic                   w_last_beat;
    logic                   w_unused;

    assign w_req_set  = r_req_addr[6 +: SET_WIDTH];
    assign w_req_tag  = r_req_addr[31 -: TAG_WIDTH];
    assign w_req_word = r_req_addr[5:2];
    assign w_rd_state = i_st_r_state_tag[STATE_WIDTH+TAG_WIDTH-1 -: STATE_WIDTH];
    assign w_rd_tag   = i_st_r_state_tag[TAG_WIDTH-1:0];
    assign w_unused   = ^r_req_addr[1:0];

    // Tag RAM output here belongs to the read issued from IDLE for this request.
    assign w_hit = (r_state == S_LOOKUP) && (w_rd_state != c_ST_INVALID) &&
                   (w_rd_state != c_ST_RSVD) && (w_rd_tag == w_req_tag);

    assign w_beat_acc  = r_rready && i_mem_rvalid;
    assign w_last_beat = w_beat_acc && (i_mem_rlast || (r_beat == c_LAST_WORD));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_req_addr  <= '0;
            r_beat      <= '0;
            r_fill_word <= '0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_update    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_cpu_req) begin
                        r_req_addr <= i_cpu_addr;
                        r_state    <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (w_hit) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_arvalid <= 1'b1;
                        r_state   <= S_AR;
                    end
                end
                S_AR: begin
                    if (i_mem_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_beat    <= '0;
                        r_state   <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (w_beat_acc) begin
                        r_beat <= r_beat + 4'd1;
                        if (r_beat == w_req_word) begin
                            r_fill_word <= i_mem_rdata;
                        end
                        if (w_last_beat) begin
                            r_rready <= 1'b0;
                            r_update <= 1'b1;
                            r_state  <= S_UPDATE;
                        end
                    end
                end
                S_UPDATE: begin
                    r_update <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_arvalid <= 1'b0;
                    r_rready  <= 1'b0;
                    r_update  <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign o_cpu_ready      = w_hit || r_update;
    assign o_cpu_rdata      = w_hit ? i_dr_rdata : (r_update ? r_fill_word : 32'd0);
    assign o_st_rw_addr     = (r_state == S_IDLE) ? i_cpu_addr[6 +: SET_WIDTH] : w_req_set;
    assign o_st_w_en        = r_update;
    assign o_st_w_state_tag = {c_ST_CLEAN, w_req_tag};
    // Refill beats land at {set, beat}; otherwise the RAM follows the fetch address.
    assign o_dr_addr        = (r_state == S_IDLE)   ? i_cpu_addr[2 +: SET_WIDTH+4] :
                              (r_state == S_REFILL) ? {w_req_set, r_beat} :
                                                      r_req_addr[2 +: SET_WIDTH+4];
    assign o_dr_w_en        = w_beat_acc;
    assign o_dr_wdata       = i_mem_rdata;
    assign o_mem_arvalid    = r_arvalid;
    assign o_mem_araddr     = {r_req_addr[31:6], 6'b0};
    assign o_mem_arlen      = c_ARLEN;
    assign o_mem_rready     = r_rready;

endmodule
`default_nettype wire

// File: tb/tb_icache_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_icache_fill_ctrl
// Brief   : Self-checking bench with RAM/memory models and a cache-level reference.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_icache_fill_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_ready, st_w_en, dr_w_en, arvalid, arready, rvalid, rlast, rready;
    logic [31:0] cpu_addr, cpu_rdata, dr_wdata, dr_rdata, araddr, rdata;
    logic [3:0]  st_rw_addr;
    logic [23:0] st_w_state_tag, st_rdata;
    logic [7:0]  dr_addr, arlen;

    always #5 clk = ~clk;

    icache_fill_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .i_cpu_req(cpu_req), .i_cpu_addr(cpu_addr),
        .o_cpu_ready(cpu_ready), .o_cpu_rdata(cpu_rdata),
        .o_st_rw_addr(st_rw_addr), .o_st_w_en(st_w_en),
        .o_st_w_state_tag(st_w_state_tag), .i_st_r_state_tag(st_rdata),
        .o_dr_addr(dr_addr), .o_dr_w_en(dr_w_en), .o_dr_wdata(dr_wdata), .i_dr_rdata(dr_rdata),
        .o_mem_arvalid(arvalid), .o_mem_araddr(araddr), .o_mem_arlen(arlen),
        .i_mem_arready(arready), .i_mem_rvalid(rvalid), .i_mem_rdata(rdata),
        .i_mem_rlast(rlast), .o_mem_rready(rready)
    );

    int tests_run = 0;
    int fails     = 0;
    int ar_unstable = 0;
    int ar_wait = 0;
    int gap_mode = 0;
    bit idx_mode = 1'b0;
    logic ram_clear;

    // State-tag and data RAMs with 1-cycle registered reads
    logic [23:0] st_ram [16];
    logic [31:0] dram [256];
    always @(posedge clk) begin
        if (ram_clear) begin
            for (int i = 0; i < 16; i++) st_ram[i] <= 24'h800000;
        end else if (st_w_en) begin
            st_ram[st_rw_addr] <= st_w_state_tag;
        end
        if (dr_w_en) dram[dr_addr] <= dr_wdata;
        st_rdata <= st_ram[st_rw_addr];
        dr_rdata <= dram[dr_addr];
    end

    logic rst_q = 1'b0, hs_ar = 1'b0, hs_r = 1'b0;
    int   refill_beats = 0;
    always @(posedge clk) begin
        rst_q <= rst_n;
        hs_ar <= rst_n && arvalid && arready;
        hs_r  <= rst_n && rvalid && rready;
        if (!rst_n || (arvalid && arready)) refill_beats <= 0;
        else if (dr_w_en) refill_beats <= refill_beats + 1;
    end

    function automatic logic [31:0] data_fn(input logic [31:0] a);
        if (idx_mode) return {28'd0, a[5:2]};
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Cache-level reference: per-set valid/tag and the line contents
    bit          m_valid [16];
    logic [21:0] m_tag   [16];
    logic [31:0] m_line  [16][16];

    function automatic bit m_hit(input logic [31:0] a);
        return m_valid[a[9:6]] && (m_tag[a[9:6]] == a[31:10]);
    endfunction
    function automatic logic [31:0] m_read(input logic [31:0] a);
        return m_hit(a) ? m_line[a[9:6]][a[5:2]] : data_fn(a);
    endfunction
    function automatic void m_fill(input logic [31:0] a);
        m_valid[a[9:6]] = 1'b1;
        m_tag[a[9:6]]   = a[31:10];
        for (int i = 0; i < 16; i++) m_line[a[9:6]][i] = data_fn({a[31:6], 6'b0} + 32'(i * 4));
    endfunction

    // Memory responder: AR acceptance after ar_wait cycles, 16 beats with optional gaps
    initial begin : responder
        logic [31:0] line, prev_addr;
        int  beat, ar_cnt;
        bit  busy, tog, prev_ar;
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = 32'd0;
        line = 32'd0; prev_addr = 32'd0; beat = 0; ar_cnt = 0; busy = 0; tog = 0; prev_ar = 0;
        forever begin
            @(negedge clk);
            if (!rst_q) begin
                busy = 0; beat = 0; ar_cnt = 0; prev_ar = 0;
                arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
            end else begin
                if (prev_ar && !hs_ar && (arvalid !== 1'b1 || araddr !== prev_addr)) ar_unstable++;
                if (hs_ar) begin busy = 1; beat = 0; tog = 0; ar_cnt = 0; line = prev_addr; end
                if (hs_r) begin beat++; if (beat == 16) busy = 0; end
                if (busy) begin
                    arready = 1'b0; prev_ar = 0;
                    case (gap_mode)
                        0:       rvalid = 1'b1;
                        1:       rvalid = tog;
                        default: rvalid = 1'($urandom_range(0, 1));
                    endcase
                    tog   = !tog;
                    rdata = data_fn(line + 32'(beat * 4));
                    rlast = (beat == 15);
                end else begin
                    rvalid = 1'b0; rlast = 1'b0;
                    if (arvalid) begin
                        arready = (ar_cnt >= ar_wait);
                        if (ar_cnt < ar_wait) ar_cnt++;
                        prev_ar = 1; prev_addr = araddr;
                    end else begin
                        arready = 1'b0; prev_ar = 0;
                    end
                end
            end
        end
    end

    // Issue one request from a negedge and collect what the DUT does until cpu_ready
    task automatic do_fetch(input logic [31:0] addr, output int lat, output logic [31:0] data,
                            output bit saw_ar, output logic [31:0] ar_addr, output logic [7:0] ar_len,
                            output bit st_wr, output logic [3:0] st_set, output logic [23:0] st_val,
                            output bit ok);
        lat = 0; data = 32'd0; saw_ar = 0; ar_addr = 32'd0; ar_len = 8'd0;
        st_wr = 0; st_set = 4'd0; st_val = 24'd0; ok = 0;
        cpu_addr = addr; cpu_req = 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            lat++;
            if (arvalid && !saw_ar) begin saw_ar = 1; ar_addr = araddr; ar_len = arlen; end
            if (st_w_en) begin st_wr = 1; st_set = st_rw_addr; st_val = st_w_state_tag; end
            if (cpu_ready) begin data = cpu_rdata; ok = 1; break; end
        end
        cpu_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        tests_run++; if (cpu_ready !== 1'b0) begin fails++; $display("FAIL reset_ready got %b exp 0", cpu_ready); end
        tests_run++; if (cpu_rdata !== 32'd0) begin fails++; $display("FAIL reset_rdata got %h exp 0", cpu_rdata); end
        tests_run++; if ({st_w_en, dr_w_en} !== 2'b00) begin fails++; $display("FAIL reset_wen got %b exp 00", {st_w_en, dr_w_en}); end
        tests_run++; if ({arvalid, rready} !== 2'b00) begin fails++; $display("FAIL reset_mem got %b exp 00", {arvalid, rready}); end
    endtask

    task automatic test_cold_miss();
        int lat; logic [31:0] d, aa; bit sa, sw, ok; logic [7:0] al; logic [3:0] ss; logic [23:0] sv;
        idx_mode = 1'b1; ar_wait = 0; gap_mode = 0;
        do_fetch(32'h0000_1044, lat, d, sa, aa, al, sw, ss, sv, ok);
        m_fill(32'h0000_1044);
        tests_run++; if (ok !== 1'b1) begin fails++; $display("FAIL cold_timeout got ok=%b exp 1", ok); end
        tests_run++; if (aa !== 32'h0000_1040 || sa !== 1'b1) begin fails++; $display("FAIL cold_araddr got %h (seen %b) exp 00001040", aa, sa); end
        tests_run++; if (al !== 8'd15) begin fails++; $display("FAIL cold_arlen got %0d exp 15", al); end
        tests_run++; if ({sw, ss, sv} !== {1'b1, 4'd1, 24'h400004}) begin fails++; $display("FAIL cold_stwrite got %b/%h/%h exp 1/1/400004", sw, ss, sv); end
        tests_run++; if (d !== 32'd1) begin fails++; $display("FAIL cold_rdata got %h exp 1", d); end
        tests_run++; if (lat !== 19) begin fails++; $display("FAIL cold_latency got %0d exp 19", lat); end
    endtask

    task automatic test_hit();
        int lat; logic [31:0] d, aa, a; bit sa, sw, ok; logic [7:0] al; logic [3:0] ss; logic [23:0] sv;
        do_fetch(32'h0000_1048, lat, d, sa, aa, al, sw, ss, sv, ok);
        tests_run++; if (d !== 32'd2 || ok !== 1'b1) begin fails++; $display("FAIL hit_rdata got %h (ok %b) exp 2", d, ok); end
        tests_run++; if (lat !== 1) begin fails++; $display("FAIL hit_latency got %0d exp 1", lat); end
        tests_run++; if (sa !== 1'b0) begin fails++; $display("FAIL hit_arvalid got %b exp 0", sa); end
        for (int k = 0; k < 4; k++) begin
            a = 32'h0000_1040 | (32'($urandom_range(0, 15)) << 2);
            do_fetch(a, lat, d, sa, aa, al, sw, ss, sv, ok);
            tests_run++;
            if (d !== m_read(a) || lat !== 1 || sa !== 1'b0) begin
                fails++; $display("FAIL hit_word addr %h got %h lat %0d ar %b exp %h lat 1 ar 0", a, d, lat, sa, m_read(a));
            end
        end
    endtask

    task automatic test_conflict();
        int lat; logic [31:0] d, aa, e; bit sa, sw, ok; logic [7:0] al; logic [3:0] ss; logic [23:0] sv;
        idx_mode = 1'b0;
        e = m_read(32'h0000_1440);
        do_fetch(32'h0000_1440, lat, d, sa, aa, al, sw, ss, sv, ok);
        m_fill(32'h0000_1440);
        tests_run++; if (sa !== 1'b1 || aa !== 32'h0000_1440) begin fails++; $display("FAIL conflict_miss got ar %b addr %h exp 1 00001440", sa, aa); end
        tests_run++; if ({sw, ss, sv} !== {1'b1, 4'd1, 24'h400005}) begin fails++; $display("FAIL conflict_tag got %b/%h/%h exp 1/1/400005", sw, ss, sv); end
        tests_run++; if (d !== e) begin fails++; $display("FAIL conflict_rdata got %h exp %h", d, e); end
        e = m_read(32'h0000_1040);
        do_fetch(32'h0000_1040, lat, d, sa, aa, al, sw, ss, sv, ok);
        m_fill(32'h0000_1040);
        tests_run++; if (sa !== 1'b1) begin fails++; $display("FAIL conflict_remiss got ar %b exp 1", sa); end
        tests_run++; if (d !== e) begin fails++; $display("FAIL conflict_rdata2 got %h exp %h", d, e); end
    endtask

    task automatic test_backpressure();
        int lat; logic [31:0] d, aa, e; bit sa, sw, ok; logic [7:0] al; logic [3:0] ss; logic [23:0] sv;
        ar_wait = 5; gap_mode = 1; ar_unstable = 0;
        e = m_read(32'h0000_20CC);
        do_fetch(32'h0000_20CC, lat, d, sa, aa, al, sw, ss, sv, ok);
        m_fill(32'h0000_20CC);
        tests_run++; if (d !== e || ok !== 1'b1) begin fails++; $display("FAIL bp_rdata got %h exp %h", d, e); end
        tests_run++; if (aa !== 32'h0000_20C0) begin fails++; $display("FAIL bp_araddr got %h exp 000020c0", aa); end
        tests_run++; if (ar_unstable !== 0) begin fails++; $display("FAIL bp_ar_stable got %0d changes exp 0", ar_unstable); end
        tests_run++; if (lat !== 40) begin fails++; $display("FAIL bp_latency got %0d exp 40", lat); end
        for (int i = 0; i < 16; i++) begin
            tests_run++;
            if (dram[8'(48 + i)] !== data_fn(32'h0000_20C0 + 32'(i * 4))) begin
                fails++; $display("FAIL bp_dram word %0d got %h exp %h", i, dram[8'(48 + i)], data_fn(32'h0000_20C0 + 32'(i * 4)));
            end
        end
        ar_wait = 0; gap_mode = 0;
    endtask

    task automatic test_reset_mid_refill();
        int lat; logic [31:0] d, aa, e; bit sa, sw, ok, reached; logic [7:0] al; logic [3:0] ss; logic [23:0] sv;
        reached = 0;
        cpu_addr = 32'h0000_3244; cpu_req = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (refill_beats == 7) begin reached = 1; break; end
        end
        tests_run++; if (reached !== 1'b1) begin fails++; $display("FAIL rst_refill_progress got %0d beats exp 7", refill_beats); end
        rst_n = 1'b0; cpu_req = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({cpu_ready, st_w_en, dr_w_en, arvalid, rready} !== 5'b0 || cpu_rdata !== 32'd0) begin
            fails++; $display("FAIL rst_outputs got %b rdata %h exp 00000 rdata 0", {cpu_ready, st_w_en, dr_w_en, arvalid, rready}, cpu_rdata);
        end
        rst_n = 1'b1;
        tests_run++; if (st_ram[9][23:22] !== 2'b10) begin fails++; $display("FAIL rst_set_state got %b exp 10", st_ram[9][23:22]); end
        @(negedge clk);
        e = m_read(32'h0000_3244);
        do_fetch(32'h0000_3244, lat, d, sa, aa, al, sw, ss, sv, ok);
        m_fill(32'h0000_3244);
        tests_run++; if (sa !== 1'b1) begin fails++; $display("FAIL rst_rerequest_miss got ar %b exp 1", sa); end
        tests_run++; if (d !== e) begin fails++; $display("FAIL rst_rerequest_rdata got %h exp %h", d, e); end
    endtask

    task automatic test_random();
        int lat; logic [31:0] d, aa, a, e; bit sa, sw, ok, h; logic [7:0] al; logic [3:0] ss; logic [23:0] sv;
        gap_mode = 2; ar_unstable = 0;
        for (int k = 0; k < 24; k++) begin
            ar_wait = int'($urandom_range(0, 3));
            a = {20'd0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2'b00};
            h = m_hit(a); e = m_read(a);
            do_fetch(a, lat, d, sa, aa, al, sw, ss, sv, ok);
            if (!h) m_fill(a);
            tests_run++;
            if (ok !== 1'b1 || d !== e || sa !== !h || (h && lat !== 1)) begin
                fails++; $display("FAIL rand addr %h got d=%h ar=%b lat=%0d exp d=%h ar=%b", a, d, sa, lat, e, !h);
            end
        end
        tests_run++; if (ar_unstable !== 0) begin fails++; $display("FAIL rand_ar_stable got %0d exp 0", ar_unstable); end
        ar_wait = 0; gap_mode = 0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] a [6];
        int k, cyc, last;
        bit extra_ar;
        for (int i = 0; i < 6; i++) begin
            logic [3:0] s;
            s = 4'd1;
            for (int t = 0; t < 50; t++) begin
                s = 4'($urandom_range(0, 15));
                if (m_valid[s]) break;
                s = 4'd1;
            end
            a[i] = {m_tag[s], s, 4'($urandom_range(0, 15)), 2'b00};
        end
        k = 0; cyc = 0; last = 0; extra_ar = 0;
        cpu_addr = a[0]; cpu_req = 1'b1;
        for (int c = 0; c < 60 && k < 6; c++) begin
            @(negedge clk);
            cyc++;
            if (arvalid) extra_ar = 1;
            if (cpu_ready) begin
                tests_run++;
                if (cpu_rdata !== m_read(a[k]) || (cyc - last) !== ((k == 0) ? 1 : 2)) begin
                    fails++; $display("FAIL b2b req %0d got %h gap %0d exp %h gap %0d", k, cpu_rdata, cyc - last, m_read(a[k]), (k == 0) ? 1 : 2);
                end
                last = cyc; k++;
                if (k < 6) cpu_addr = a[k];
            end
        end
        cpu_req = 1'b0;
        @(negedge clk);
        tests_run++; if (k !== 6 || extra_ar !== 1'b0) begin fails++; $display("FAIL b2b_count got %0d readies ar %b exp 6 ar 0", k, extra_ar); end
    endtask

    initial begin
        cpu_req = 1'b0; cpu_addr = 32'd0; rst_n = 1'b0; ram_clear = 1'b1;
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        repeat (3) @(negedge clk);
        ram_clear = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_backpressure();
        test_reset_mid_refill();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
`default_nettype wire
